// File: rtl/decode_stage_pipe_if.sv
// Decode-stage bus: decode-side inputs, writeback port, execute-side hazard
// controls, and the registered execute-stage outputs.
interface decode_stage_pipe_if #(
  parameter int DATA_W = 22
);
  logic              valid_d_in;
  logic [21:0]       instruction_d_in;
  logic [DATA_W-1:0] pc_plus_8_in;
  logic              reg_write_w_in;
  logic [3:0]        write_register_w_in;
  logic [DATA_W-1:0] result_w_in;
  logic              stall_e_in;
  logic              flush_e_in;

  logic [DATA_W-1:0] rd1_e;
  logic [DATA_W-1:0] rd2_e;
  logic [DATA_W-1:0] rd3_e;
  logic [DATA_W-1:0] imm_ext_e;
  logic [3:0]        ra1_e;
  logic [3:0]        ra2_e;
  logic [3:0]        write_register_e;
  logic              reg_write_e;
  logic              mem_write_e;
  logic              mem_reg_e;
  logic              alu_src_e;
  logic              no_write_e;
  logic              mov_src_e;
  logic              pc_src_e;
  logic              flag_write_e;
  logic [1:0]        alu_control_e;
  logic              valid_e;
  logic              stall_d_out;

  modport master (
    output valid_d_in, instruction_d_in, pc_plus_8_in,
    output reg_write_w_in, write_register_w_in, result_w_in,
    output stall_e_in, flush_e_in,
    input  rd1_e, rd2_e, rd3_e, imm_ext_e, ra1_e, ra2_e, write_register_e,
    input  reg_write_e, mem_write_e, mem_reg_e, alu_src_e, no_write_e,
    input  mov_src_e, pc_src_e, flag_write_e, alu_control_e, valid_e,
    input  stall_d_out
  );

  modport slave (
    input  valid_d_in, instruction_d_in, pc_plus_8_in,
    input  reg_write_w_in, write_register_w_in, result_w_in,
    input  stall_e_in, flush_e_in,
    output rd1_e, rd2_e, rd3_e, imm_ext_e, ra1_e, ra2_e, write_register_e,
    output reg_write_e, mem_write_e, mem_reg_e, alu_src_e, no_write_e,
    output mov_src_e, pc_src_e, flag_write_e, alu_control_e, valid_e,
    output stall_d_out
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// Decode stage: 16-entry regfile, decoder, D->E register; one cycle latency, stall_e_in freezes,
// load-use inserts one bubble via stall_d_out. Define DECODE_WB_BYPASS_EN for same-cycle writeback bypass.
module decode_stage_pipe #(
  parameter int DATA_W = 22,
  parameter int PC_REG = 11
) (
  input logic           clk,
  input logic           rst,
  decode_stage_pipe_if.slave bus
);
  localparam logic [3:0] PC_IDX = 4'(PC_REG);
  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_reg;
    logic       alu_src;
    logic       no_write;
    logic       mov_src;
    logic       pc_src;
    logic       flag_write;
    logic [1:0] alu_control;
  } ctrl_t;

  logic [1:0] op;
  logic [3:0] funct;
  logic [3:0] ra1;
  logic [3:0] rd;
  logic [3:0] ra2;
  logic       unused_instr_msb;

  assign op               = bus.instruction_d_in[20:19];
  assign funct            = bus.instruction_d_in[18:15];
  assign ra1              = bus.instruction_d_in[14:11];
  assign rd               = bus.instruction_d_in[10:7];
  assign ra2              = bus.instruction_d_in[6:3];
  assign unused_instr_msb = bus.instruction_d_in[21];

  // Register file; the PC_REG slot is never written since its reads come from pc_plus_8_in.
  logic [DATA_W-1:0] rf [16];
  logic              wb_hit;

  assign wb_hit = bus.reg_write_w_in && (bus.write_register_w_in != PC_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (wb_hit) begin
      rf[bus.write_register_w_in] <= bus.result_w_in;
    end
  end

  logic [2:0] byp;
`ifdef DECODE_WB_BYPASS_EN
  assign byp[0] = wb_hit && (bus.write_register_w_in == ra1);
  assign byp[1] = wb_hit && (bus.write_register_w_in == ra2);
  assign byp[2] = wb_hit && (bus.write_register_w_in == rd);
`else
  assign byp = 3'b000;
`endif

  logic [DATA_W-1:0] rd1_d;
  logic [DATA_W-1:0] rd2_d;
  logic [DATA_W-1:0] rd3_d;

  assign rd1_d = (ra1 == PC_IDX) ? bus.pc_plus_8_in : byp[0] ? bus.result_w_in : rf[ra1];
  assign rd2_d = (ra2 == PC_IDX) ? bus.pc_plus_8_in : byp[1] ? bus.result_w_in : rf[ra2];
  assign rd3_d = (rd  == PC_IDX) ? bus.pc_plus_8_in : byp[2] ? bus.result_w_in : rf[rd];

  ctrl_t             ctrl_d;
  logic [DATA_W-1:0] imm_d;
  logic [DATA_W-1:0] br_off;

  assign br_off = {{(DATA_W-19){bus.instruction_d_in[18]}}, bus.instruction_d_in[18:0]};

  always_comb begin
    ctrl_d = '0;
    imm_d  = DATA_W'(bus.instruction_d_in[6:0]);
    case (op)
      OP_ALU: begin
        ctrl_d.alu_src     = funct[3];
        ctrl_d.alu_control = funct[2:1];
        ctrl_d.flag_write  = funct[0];
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.no_write    = &funct[2:1];
      end
      OP_MEM: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = funct[0];
        ctrl_d.mem_reg   = funct[0];
        ctrl_d.mem_write = ~funct[0];
      end
      OP_BR: begin
        ctrl_d.pc_src  = 1'b1;
        ctrl_d.alu_src = 1'b1;
        imm_d          = br_off << 2;
      end
      default: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.mov_src   = 1'b1;
        ctrl_d.alu_src   = funct[3];
      end
    endcase
    if (!bus.valid_d_in) ctrl_d = '0;
  end

  ctrl_t             ctrl_q;
  logic              valid_q;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic [DATA_W-1:0] rd3_q;
  logic [DATA_W-1:0] imm_q;
  logic [3:0]        ra1_q;
  logic [3:0]        ra2_q;
  logic [3:0]        wr_q;
  logic              load_use;

  // A load in execute targeting a source of the decoding instruction is not ready for it.
  assign load_use = valid_q && ctrl_q.mem_reg && bus.valid_d_in && (wr_q != PC_IDX) &&
                    ((wr_q == ra1) || (wr_q == ra2));

  assign bus.stall_d_out = bus.stall_e_in || (load_use && !bus.flush_e_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rd3_q   <= '0;
      imm_q   <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      wr_q    <= '0;
    end else if (bus.flush_e_in) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (!bus.stall_e_in) begin
      valid_q <= bus.valid_d_in && !load_use;
      ctrl_q  <= load_use ? '0 : ctrl_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      rd3_q   <= rd3_d;
      imm_q   <= imm_d;
      ra1_q   <= ra1;
      ra2_q   <= ra2;
      wr_q    <= rd;
    end
  end

  assign bus.rd1_e            = rd1_q;
  assign bus.rd2_e            = rd2_q;
  assign bus.rd3_e            = rd3_q;
  assign bus.imm_ext_e        = imm_q;
  assign bus.ra1_e            = ra1_q;
  assign bus.ra2_e            = ra2_q;
  assign bus.write_register_e = wr_q;
  assign bus.reg_write_e      = ctrl_q.reg_write;
  assign bus.mem_write_e      = ctrl_q.mem_write;
  assign bus.mem_reg_e        = ctrl_q.mem_reg;
  assign bus.alu_src_e        = ctrl_q.alu_src;
  assign bus.no_write_e       = ctrl_q.no_write;
  assign bus.mov_src_e        = ctrl_q.mov_src;
  assign bus.pc_src_e         = ctrl_q.pc_src;
  assign bus.flag_write_e     = ctrl_q.flag_write;
  assign bus.alu_control_e    = ctrl_q.alu_control;
  assign bus.valid_e          = valid_q;
endmodule
